// File: rtl/stage4_mem_access.sv
// Memory-access pipeline stage: turns an execute-stage op into at most one
// data-memory transaction and presents the result to writeback.
module stage4_mem_access (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  func3,
    input  logic [4:0]  rd,
    input  logic        reg_write,
    output logic        ex_ready,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic        wb_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        DONE     = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        dmem_req_q, dmem_req_d;
    logic        dmem_we_q, dmem_we_d;
    logic [31:0] dmem_addr_q, dmem_addr_d;
    logic [3:0]  dmem_be_q, dmem_be_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;
    logic        wb_valid_q, wb_valid_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_reg_write_q, wb_reg_write_d;
    logic        wb_err_q, wb_err_d;
    logic [2:0]  func3_q, func3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic        ex_ready_s;
    logic        accept_s;

    // Misalignment, unsupported sizes and contradictory read+write requests.
    function automatic logic is_illegal(input logic rd_f, input logic wr_f,
                                        input logic [2:0] f3, input logic [1:0] a);
        logic bad;
        bad = 1'b0;
        if (rd_f && wr_f) begin
            bad = 1'b1;
        end else begin
            case (f3)
                3'b000:  bad = 1'b0;
                3'b001:  bad = a[0];
                3'b010:  bad = (a != 2'b00);
                3'b100:  bad = wr_f;
                3'b101:  bad = wr_f | a[0];
                default: bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] be;
        case (f3)
            3'b000:  be = 4'b0001 << a;
            3'b001:  be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] w;
        case (f3)
            3'b000:  w = {4{sd[7:0]}};
            3'b001:  w = {2{sd[15:0]}};
            default: w = sd;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'b00:   b = rdata[7:0];
            2'b01:   b = rdata[15:8];
            2'b10:   b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = a[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    assign ex_ready_s = (state_q == IDLE) || ((state_q == DONE) && wb_ready);
    assign accept_s   = ex_valid && ex_ready_s;

    // Next-state and next-output computation; a new op accepted in DONE overrides the return to IDLE.
    always_comb begin
        state_d        = state_q;
        dmem_req_d     = dmem_req_q;
        dmem_we_d      = dmem_we_q;
        dmem_addr_d    = dmem_addr_q;
        dmem_be_d      = dmem_be_q;
        dmem_wdata_d   = dmem_wdata_q;
        wb_valid_d     = wb_valid_q;
        wb_data_d      = wb_data_q;
        wb_rd_d        = wb_rd_q;
        wb_reg_write_d = wb_reg_write_q;
        wb_err_d       = wb_err_q;
        func3_d        = func3_q;
        addr_lo_d      = addr_lo_q;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            MEM_WAIT: begin
                if (dmem_ack) begin
                    state_d    = DONE;
                    dmem_req_d = 1'b0;
                    wb_valid_d = 1'b1;
                    if (!dmem_we_q) begin
                        wb_data_d = load_extend(func3_q, addr_lo_q, dmem_rdata);
                    end else begin
                        wb_data_d = wb_data_q;
                    end
                end else begin
                    state_d = MEM_WAIT;
                end
            end
            DONE: begin
                if (wb_ready) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b0;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d    = IDLE;
                dmem_req_d = 1'b0;
                wb_valid_d = 1'b0;
            end
        endcase

        if (accept_s) begin
            func3_d   = func3;
            addr_lo_d = alu_result[1:0];
            wb_rd_d   = rd;
            wb_data_d = alu_result;
            if (!mem_read && !mem_write) begin
                state_d        = DONE;
                wb_valid_d     = 1'b1;
                wb_reg_write_d = reg_write;
                wb_err_d       = 1'b0;
            end else if (is_illegal(mem_read, mem_write, func3, alu_result[1:0])) begin
                state_d        = DONE;
                wb_valid_d     = 1'b1;
                wb_reg_write_d = 1'b0;
                wb_err_d       = 1'b1;
            end else begin
                state_d        = MEM_WAIT;
                wb_valid_d     = 1'b0;
                wb_reg_write_d = mem_read & reg_write;
                wb_err_d       = 1'b0;
                dmem_req_d     = 1'b1;
                dmem_we_d      = mem_write;
                dmem_addr_d    = {alu_result[31:2], 2'b00};
                dmem_be_d      = mem_write ? store_be(func3, alu_result[1:0]) : 4'b1111;
                dmem_wdata_d   = mem_write ? store_wdata(func3, store_data) : 32'd0;
            end
        end else begin
            func3_d = func3_q;
        end
    end

    // State and output registers; reset abandons any outstanding access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            dmem_req_q     <= 1'b0;
            dmem_we_q      <= 1'b0;
            dmem_addr_q    <= 32'd0;
            dmem_be_q      <= 4'd0;
            dmem_wdata_q   <= 32'd0;
            wb_valid_q     <= 1'b0;
            wb_data_q      <= 32'd0;
            wb_rd_q        <= 5'd0;
            wb_reg_write_q <= 1'b0;
            wb_err_q       <= 1'b0;
            func3_q        <= 3'd0;
            addr_lo_q      <= 2'd0;
        end else begin
            state_q        <= state_d;
            dmem_req_q     <= dmem_req_d;
            dmem_we_q      <= dmem_we_d;
            dmem_addr_q    <= dmem_addr_d;
            dmem_be_q      <= dmem_be_d;
            dmem_wdata_q   <= dmem_wdata_d;
            wb_valid_q     <= wb_valid_d;
            wb_data_q      <= wb_data_d;
            wb_rd_q        <= wb_rd_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_err_q       <= wb_err_d;
            func3_q        <= func3_d;
            addr_lo_q      <= addr_lo_d;
        end
    end

    assign ex_ready     = ex_ready_s;
    assign dmem_req     = dmem_req_q;
    assign dmem_we      = dmem_we_q;
    assign dmem_addr    = dmem_addr_q;
    assign dmem_be      = dmem_be_q;
    assign dmem_wdata   = dmem_wdata_q;
    assign wb_valid     = wb_valid_q;
    assign wb_data      = wb_data_q;
    assign wb_rd        = wb_rd_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_err       = wb_err_q;

endmodule

// File: tb/tb_stage4_mem_access.sv
// Directed self-checking bench for stage4_mem_access with hand-computed expectations.
module tb_stage4_mem_access;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  func3;
    logic [4:0]  rd;
    logic        reg_write;
    logic        ex_ready;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        wb_err;

    int n_cmp = 0;
    int n_err = 0;

    int          req_cycles;
    logic [31:0] o_addr;
    logic [3:0]  o_be;
    logic [31:0] o_wdata;
    logic        o_we;

    stage4_mem_access dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .alu_result(alu_result),
        .store_data(store_data), .mem_read(mem_read), .mem_write(mem_write),
        .func3(func3), .rd(rd), .reg_write(reg_write), .ex_ready(ex_ready),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_data(wb_data), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [31:0] a, input logic [31:0] sd, input logic [2:0] f3,
                            input logic mr, input logic mw, input logic [4:0] r, input logic rw);
        ex_valid   = 1'b1;
        alu_result = a;
        store_data = sd;
        func3      = f3;
        mem_read   = mr;
        mem_write  = mw;
        rd         = r;
        reg_write  = rw;
    endtask

    // Issue one memory op from IDLE, acknowledge on the ack_at-th request cycle, stop in DONE.
    task automatic mem_op(input logic [31:0] a, input logic [31:0] sd, input logic [2:0] f3,
                          input logic mr, input logic mw, input logic [4:0] r, input logic rw,
                          input logic [31:0] rdata, input int ack_at,
                          output int cyc, output logic [31:0] oa, output logic [3:0] ob,
                          output logic [31:0] ow, output logic owe);
        wb_ready = 1'b1;
        drive_op(a, sd, f3, mr, mw, r, rw);
        step();
        ex_valid = 1'b0;
        cyc = 0;
        oa  = dmem_addr;
        ob  = dmem_be;
        ow  = dmem_wdata;
        owe = dmem_we;
        for (int i = 0; i < 20; i++) begin
            if (!dmem_req) break;
            cyc++;
            check_eq("addr_stable", dmem_addr, oa);
            if (cyc == ack_at) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdata;
            end
            step();
            dmem_ack = 1'b0;
        end
    endtask

    task automatic retire();
        step();
        check_eq("retire_wb_valid", 32'(wb_valid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; alu_result = 32'd0; store_data = 32'd0;
        mem_read = 1'b0; mem_write = 1'b0; func3 = 3'd0; rd = 5'd0; reg_write = 1'b0;
        dmem_ack = 1'b0; dmem_rdata = 32'd0; wb_ready = 1'b1;
        #12;
        check_eq("rst_dmem_req", 32'(dmem_req), 32'd0);
        check_eq("rst_dmem_be", 32'(dmem_be), 32'd0);
        check_eq("rst_dmem_addr", dmem_addr, 32'd0);
        check_eq("rst_wb_valid", 32'(wb_valid), 32'd0);
        check_eq("rst_wb_data", wb_data, 32'd0);
        #3 rst_n = 1'b1;
        step();
        check_eq("idle_ex_ready", 32'(ex_ready), 32'd1);

        // ALU pass-through, latency 1
        drive_op(32'h0000_1234, 32'd0, 3'b000, 1'b0, 1'b0, 5'd5, 1'b1);
        step();
        ex_valid = 1'b0;
        check_eq("alu_wb_valid", 32'(wb_valid), 32'd1);
        check_eq("alu_wb_data", wb_data, 32'h0000_1234);
        check_eq("alu_wb_rd", 32'(wb_rd), 32'd5);
        check_eq("alu_wb_reg_write", 32'(wb_reg_write), 32'd1);
        check_eq("alu_wb_err", 32'(wb_err), 32'd0);
        check_eq("alu_no_req", 32'(dmem_req), 32'd0);
        retire();

        // LB from 0x103, ack on third request cycle
        mem_op(32'h0000_0103, 32'd0, 3'b000, 1'b1, 1'b0, 5'd7, 1'b1, 32'h8000_0000, 3,
               req_cycles, o_addr, o_be, o_wdata, o_we);
        check_eq("lb_req_cycles", 32'(req_cycles), 32'd3);
        check_eq("lb_addr", o_addr, 32'h0000_0100);
        check_eq("lb_be", 32'(o_be), 32'hF);
        check_eq("lb_we", 32'(o_we), 32'd0);
        check_eq("lb_wb_valid", 32'(wb_valid), 32'd1);
        check_eq("lb_wb_data", wb_data, 32'hFFFF_FF80);
        check_eq("lb_wb_rd", 32'(wb_rd), 32'd7);
        check_eq("lb_wb_reg_write", 32'(wb_reg_write), 32'd1);
        retire();

        // SH to 0x202
        mem_op(32'h0000_0202, 32'h0000_ABCD, 3'b001, 1'b0, 1'b1, 5'd3, 1'b1, 32'd0, 1,
               req_cycles, o_addr, o_be, o_wdata, o_we);
        check_eq("sh_req_cycles", 32'(req_cycles), 32'd1);
        check_eq("sh_we", 32'(o_we), 32'd1);
        check_eq("sh_addr", o_addr, 32'h0000_0200);
        check_eq("sh_be", 32'(o_be), 32'hC);
        check_eq("sh_wdata", o_wdata, 32'hABCD_ABCD);
        check_eq("sh_wb_reg_write", 32'(wb_reg_write), 32'd0);
        check_eq("sh_wb_err", 32'(wb_err), 32'd0);
        retire();

        // SB to 0x101
        mem_op(32'h0000_0101, 32'h1234_5678, 3'b000, 1'b0, 1'b1, 5'd3, 1'b0, 32'd0, 2,
               req_cycles, o_addr, o_be, o_wdata, o_we);
        check_eq("sb_be", 32'(o_be), 32'h2);
        check_eq("sb_wdata", o_wdata, 32'h7878_7878);
        retire();

        // LHU upper half, LH lower half sign-extended, LW
        mem_op(32'h0000_0202, 32'd0, 3'b101, 1'b1, 1'b0, 5'd9, 1'b1, 32'h8765_4321, 1,
               req_cycles, o_addr, o_be, o_wdata, o_we);
        check_eq("lhu_wb_data", wb_data, 32'h0000_8765);
        retire();
        mem_op(32'h0000_0200, 32'd0, 3'b001, 1'b1, 1'b0, 5'd9, 1'b1, 32'h0000_F00F, 1,
               req_cycles, o_addr, o_be, o_wdata, o_we);
        check_eq("lh_wb_data", wb_data, 32'hFFFF_F00F);
        retire();
        mem_op(32'h0000_0008, 32'd0, 3'b010, 1'b1, 1'b0, 5'd10, 1'b1, 32'hDEAD_BEEF, 2,
               req_cycles, o_addr, o_be, o_wdata, o_we);
        check_eq("lw_wb_data", wb_data, 32'hDEAD_BEEF);
        check_eq("lw_addr", o_addr, 32'h0000_0008);
        retire();

        // Misaligned LW: no memory request, error reported next cycle
        drive_op(32'h0000_0006, 32'd0, 3'b010, 1'b1, 1'b0, 5'd4, 1'b1);
        step();
        ex_valid = 1'b0;
        check_eq("mis_no_req", 32'(dmem_req), 32'd0);
        check_eq("mis_wb_valid", 32'(wb_valid), 32'd1);
        check_eq("mis_wb_err", 32'(wb_err), 32'd1);
        check_eq("mis_wb_reg_write", 32'(wb_reg_write), 32'd0);
        check_eq("mis_wb_data", wb_data, 32'h0000_0006);
        retire();

        // Store with unsigned size is illegal
        drive_op(32'h0000_0010, 32'd0, 3'b100, 1'b0, 1'b1, 5'd4, 1'b0);
        step();
        ex_valid = 1'b0;
        check_eq("sbu_no_req", 32'(dmem_req), 32'd0);
        check_eq("sbu_wb_err", 32'(wb_err), 32'd1);
        retire();

        // Backpressure in DONE, stray ack ignored, then back-to-back acceptance
        wb_ready = 1'b0;
        drive_op(32'h0000_0011, 32'd0, 3'b000, 1'b0, 1'b0, 5'd1, 1'b1);
        step();
        drive_op(32'h0000_0022, 32'd0, 3'b000, 1'b0, 1'b0, 5'd2, 1'b1);
        dmem_ack = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("bp_ex_ready", 32'(ex_ready), 32'd0);
            check_eq("bp_wb_valid", 32'(wb_valid), 32'd1);
            check_eq("bp_wb_data", wb_data, 32'h0000_0011);
            check_eq("bp_wb_rd", 32'(wb_rd), 32'd1);
            step();
        end
        dmem_ack = 1'b0;
        wb_ready = 1'b1;
        #1;
        check_eq("b2b_ex_ready", 32'(ex_ready), 32'd1);
        step();
        ex_valid = 1'b0;
        check_eq("b2b_wb_valid", 32'(wb_valid), 32'd1);
        check_eq("b2b_wb_data", wb_data, 32'h0000_0022);
        check_eq("b2b_wb_rd", 32'(wb_rd), 32'd2);
        retire();

        // Reset while waiting for memory, then a late ack
        drive_op(32'h0000_0010, 32'd0, 3'b010, 1'b1, 1'b0, 5'd6, 1'b1);
        step();
        ex_valid = 1'b0;
        check_eq("rw_req_before", 32'(dmem_req), 32'd1);
        step();
        #2 rst_n = 1'b0;
        #1;
        check_eq("rw_req_async", 32'(dmem_req), 32'd0);
        check_eq("rw_addr_async", dmem_addr, 32'd0);
        check_eq("rw_wb_valid_async", 32'(wb_valid), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        dmem_ack = 1'b1;
        dmem_rdata = 32'h5555_5555;
        step();
        dmem_ack = 1'b0;
        check_eq("rw_late_ack_valid", 32'(wb_valid), 32'd0);
        check_eq("rw_late_ack_req", 32'(dmem_req), 32'd0);
        check_eq("rw_ex_ready", 32'(ex_ready), 32'd1);
        step();
        check_eq("rw_still_idle", 32'(wb_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
